// File: rtl/hash_verify_pkg.sv
// rtl/hash_verify_pkg.sv - shared state encoding and sizing helpers for the digest verifier
package hash_verify_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  // Number of reference words making up one digest.
  function automatic int word_count(input int l, input int w);
    return l / w;
  endfunction

  // Counter must be able to hold N so it never wraps inside a transaction.
  function automatic int cnt_width(input int l, input int w);
    return $clog2(l / w + 1);
  endfunction

endpackage

// File: rtl/hash_verify_acc.sv
// rtl/hash_verify_acc.sv - one-word XOR/OR difference accumulator with clear and enable
module hash_verify_acc #(
  parameter int w = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  output logic         clean
);

  logic [w-1:0] diff;
  logic [w-1:0] diff_next;

  // Fold the word difference in; clean looks ahead so the verdict can be
  // registered on the same edge that absorbs the last word.
  always_comb begin
    diff_next = diff;
    if (en) diff_next = diff | (a ^ b);
  end

  assign clean = (diff_next == '0);

  // Accumulator register, cleared at reset and at the start of each verify.
  always_ff @(posedge clk) begin
    if (rst || clr) diff <= '0;
    else            diff <= diff_next;
  end

endmodule

// File: rtl/hash_verify.sv
// rtl/hash_verify.sv - constant-time digest verifier; HASH_VERIFY_DUAL_EN adds a redundant comparator
module hash_verify
  import hash_verify_pkg::*;
#(
  parameter int l = 256,
  parameter int w = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [w-1:0] ref_data,
  input  logic         ref_valid,
  output logic         ref_ready,
  input  logic [l-1:0] hash_text,
  input  logic         hash_ready,
  output logic         done,
  output logic         match,
  output logic         fault
);

  localparam int N  = word_count(l, w);
  localparam int CW = cnt_width(l, w);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [w-1:0]    ref_mem [N];
  logic [l-1:0]    snap;
  logic [w-1:0]    ref_word;
  logic [w-1:0]    snap_word;
  logic            acc_clr;
  logic            acc_en;
  logic            clean1;
  logic            disagree;

  assign idx      = cnt[IW-1:0];
  assign ref_word = ref_mem[idx];
  assign acc_clr  = (state == S_IDLE) && start;
  assign acc_en   = (state == S_CMP);

  // Pick snapshot word idx in big-endian order (word 0 is the top w bits).
  always_comb begin
    snap_word = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) snap_word = snap[l-1-k*w -: w];
    end
  end

  hash_verify_acc #(.w(w)) u_acc1 (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .en    (acc_en),
    .a     (ref_word),
    .b     (snap_word),
    .clean (clean1)
  );

`ifdef HASH_VERIFY_DUAL_EN
  logic clean2;

  // Complemented operands give the same answer when healthy, so a glitch
  // hitting only one datapath shows up as a disagreement.
  hash_verify_acc #(.w(w)) u_acc2 (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .en    (acc_en),
    .a     (~ref_word),
    .b     (~snap_word),
    .clean (clean2)
  );

  assign disagree = (clean1 != clean2);
`else
  assign disagree = 1'b0;
`endif

  // Control FSM: load reference words, snapshot the core digest, sweep all
  // N words without early exit, then report the verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      snap      <= '0;
      ref_ready <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
      fault     <= 1'b0;
      for (int k = 0; k < N; k++) ref_mem[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            match     <= 1'b0;
            fault     <= 1'b0;
            cnt       <= '0;
            ref_ready <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (ref_valid && ref_ready) begin
            ref_mem[idx] <= ref_data;
            if (cnt == CW'(N-1)) begin
              cnt       <= '0;
              ref_ready <= 1'b0;
              state     <= S_WAIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (hash_ready) begin
            snap  <= hash_text;
            state <= S_CMP;
          end
        end
        S_CMP: begin
          if (cnt == CW'(N-1)) begin
            cnt   <= '0;
            done  <= 1'b1;
            match <= clean1 && !disagree;
            fault <= disagree;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          ref_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_verify.sv
// tb/tb_hash_verify.sv - randomized self-checking bench for hash_verify against a behavioural model
module tb_hash_verify;

  localparam int L = 256;
  localparam int W = 64;
  localparam int N = L / W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] ref_data = '0;
  logic         ref_valid = 1'b0;
  logic         ref_ready;
  logic [L-1:0] hash_text = '0;
  logic         hash_ready = 1'b0;
  logic         done;
  logic         match;
  logic         fault;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int hs_cyc = -1;
  logic [W-1:0] hs_q[$];
  logic [W-1:0] words [N];
  logic [L-1:0] hash_tx;
  bit           dual_force = 1'b0;

  hash_verify #(.l(L), .w(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ref_data   (ref_data),
    .ref_valid  (ref_valid),
    .ref_ready  (ref_ready),
    .hash_text  (hash_text),
    .hash_ready (hash_ready),
    .done       (done),
    .match      (match),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Cycle n is the period after edge n; events seen at edge n+1 belong to cycle n.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && ref_valid && ref_ready) begin
      hs_q.push_back(ref_data);
      hs_cyc = cyc - 1;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [L-1:0] cat_words();
    logic [L-1:0] c;
    c = '0;
    for (int k = 0; k < N; k++) c = (c << W) | L'(words[k]);
    return c;
  endfunction

  task automatic run_txn(input int vmode, input int hdelay, input bit pulse_start,
                         input bit rst_cmp, input bit scramble);
    int i, guard, c, h, exp_done;
    bit hs, exp_match;
    hs_q = {};
    done_cnt = 0;
    done_cyc = -1;
    hash_text  = hash_tx;
    hash_ready = (hdelay == 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("ref_ready_after_start", ref_ready, 1);
    i = 0;
    guard = 0;
    while (i < N && guard < 100) begin
      case (vmode)
        0:       ref_valid = 1'b1;
        1:       ref_valid = (guard % 2 == 0);
        default: ref_valid = 1'($urandom_range(0, 1));
      endcase
      ref_data = words[i];
      start = (pulse_start && i == 1);
      hs = ref_valid && ref_ready;
      tick;
      guard++;
      if (hs) i++;
    end
    start = 1'b0;
    ref_valid = 1'b0;
    check("words_loaded", i, N);
    c = hs_cyc;
    check("ref_ready_after_last", ref_ready, 0);
    if (hdelay > 0) begin
      while (cyc < c + hdelay) tick;
      hash_ready = 1'b1;
      h = cyc;
    end else begin
      h = c + 1;
    end
    exp_done = h + N + 1;
    if (scramble) begin
      while (cyc < h + 1) tick;
      hash_text  = ~hash_text;
      hash_ready = 1'b0;
    end
    if (rst_cmp) begin
      while (cyc < h + 2) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("rst_ref_ready", ref_ready, 0);
      check("rst_done", done, 0);
      check("rst_match", match, 0);
      check("rst_fault", fault, 0);
      repeat (10) tick;
      check("rst_no_done", done_cnt, 0);
      hash_ready = 1'b0;
      return;
    end
    if (pulse_start) begin
      while (cyc < h + 2) tick;
      start = 1'b1;
      tick;
      start = 1'b0;
    end
    guard = 0;
    while (done_cnt == 0 && guard < 40) begin
      tick;
      guard++;
    end
    exp_match = (cat_words() == hash_tx) && !dual_force;
    check("done_seen", (done_cnt != 0), 1);
    check("done_cycle", done_cyc, exp_done);
    check("match", match, exp_match);
    check("fault", fault, dual_force);
    tick;
    tick;
    check("done_single", done_cnt, 1);
    check("idle_after_done", ref_ready, 0);
    check("match_held", match, exp_match);
    check("hs_count", hs_q.size(), N);
    for (int k = 0; k < N && k < hs_q.size(); k++) check("hs_word", hs_q[k], words[k]);
    hash_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick;
    check("reset_ref_ready", ref_ready, 0);
    check("reset_done", done, 0);
    check("reset_match", match, 0);
    check("reset_fault", fault, 0);
    rst = 1'b0;
    tick;
    check("idle_ref_ready", ref_ready, 0);

    words[0] = 64'h0123456789ABCDEF;
    words[1] = 64'hFEDCBA9876543210;
    words[2] = 64'h0;
    words[3] = 64'hFFFFFFFFFFFFFFFF;
    hash_tx = cat_words();
    run_txn(0, 0, 1'b0, 1'b0, 1'b0);

    hash_tx = cat_words();
    hash_tx[0] = ~hash_tx[0];
    run_txn(0, 0, 1'b0, 1'b0, 1'b0);

    hash_tx = cat_words();
    run_txn(1, 10, 1'b0, 1'b0, 1'b0);
    run_txn(0, 0, 1'b1, 1'b0, 1'b0);
    run_txn(0, 0, 1'b0, 1'b1, 1'b0);
    run_txn(2, 3, 1'b0, 1'b0, 1'b1);

    repeat (10) begin
      for (int k = 0; k < N; k++) words[k] = {$urandom, $urandom};
      hash_tx = cat_words();
      if ($urandom_range(0, 1) == 1) hash_tx[$urandom_range(0, L-1)] ^= 1'b1;
      run_txn($urandom_range(0, 2), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
              1'b0, 1'($urandom_range(0, 1)));
    end

`ifdef HASH_VERIFY_DUAL_EN
    hash_tx = cat_words();
    dual_force = 1'b1;
    force dut.u_acc2.diff = '1;
    run_txn(0, 0, 1'b0, 1'b0, 1'b0);
    release dut.u_acc2.diff;
    dual_force = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    run_txn(0, 0, 1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hash_verify.md
# hash_verify

Digest verifier for the Ascon hashing datapath. Accepts a reference digest as a stream of words over a valid/ready handshake, waits for the hash core (plain or fault-protected) to present its result, then compares the two in constant time. It reports a one-cycle `done` pulse with a held `match` verdict. It is the consuming end of the hash core's `hash_text`/`ready` output.

## Interface
Parameters:
- `l`, default 256: digest width in bits; must be a multiple of `w`.
- `w`, default 64: reference word width in bits.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a verify transaction; honoured only in IDLE.
- `ref_data`  in  w  reference digest word.
- `ref_valid`  in  1  `ref_data` is valid.
- `ref_ready`  out  1  block accepts a reference word this cycle.
- `hash_text`  in  l  digest from the hash core.
- `hash_ready`  in  1  level signal from the hash core: `hash_text` is valid.
- `done`  out  1  one-cycle pulse: verdict is valid.
- `match`  out  1  1 = digests equal; held until the next accepted `start`.
- `fault`  out  1  internal comparator disagreement (see Configuration); held like `match`.

## Operation
- N = l/w words. Word k (k = 0..N-1) is compared against `hash_text[l-1-k*w -: w]` (MSB-first, big-endian digest order).
- States:
  - IDLE: `ref_ready`=0. On `start`, clear `match`, `fault`, the word counter and the difference accumulator, then go to LOAD.
  - LOAD: `ref_ready`=1. Each `ref_valid & ref_ready` stores word[counter] and increments the counter. After word N-1 is accepted, go to WAIT. `ref_ready` is 0 in the following cycle.
  - WAIT: when `hash_ready`=1, snapshot `hash_text` into an internal l-bit register and go to CMP. If `hash_ready` is already high on entry, WAIT still lasts exactly one cycle.
  - CMP: one word per cycle for N cycles. `diff |= ref_word[k] ^ snap_word[k]`. There is no early exit on a mismatch; every verify uses the same number of cycles.
  - DONE: `done`=1 for one cycle, `match` = (diff == 0). Then return to IDLE.
- `start` outside IDLE is ignored.
- After the snapshot is taken, changes on `hash_text` and `hash_ready` have no effect.
- `rst` at any cycle returns the FSM to IDLE and clears the stored words, snapshot, diff and counter. All outputs are forced to their reset values in the next cycle.

## Timing
- Reset values: `ref_ready`=0, `done`=0, `match`=0, `fault`=0.
- `start` sampled at cycle t → LOAD at t+1, `ref_ready`=1 at t+1.
- Maximum reference throughput: one word per cycle.
- Last word accepted at cycle c, with `hash_ready` high → WAIT at c+1, CMP from c+2 to c+N+1, DONE (`done`=1) at c+N+2.
- `hash_ready` first seen at cycle h ≥ c+1 → `done` at h+N+1.
- `match` and `fault` update in the same cycle as `done`.
- Counter width is clog2(N+1). The counter never wraps inside a transaction.

## Configuration
- Macro `HASH_VERIFY_DUAL_EN`.
- Defined:
  - A second, independent accumulator computes `diff2 |= ~ref_word ^ ~snap_word` in parallel with the first.
  - In DONE, if (diff==0) differs from (diff2==0), then `fault`=1 and `match` is forced to 0.
- Undefined: the second accumulator is absent and `fault` is tied to 0.
- Latency is identical in both builds.

## Structure
- Package `hash_verify_pkg`:
  - FSM state encoding: IDLE, LOAD, WAIT, CMP, DONE.
  - Helper function for the N = l/w word count and the counter width.
- Sub-module `hash_verify_acc`: a one-word XOR/OR difference accumulator with clear and enable inputs. It is instantiated once, or twice when `HASH_VERIFY_DUAL_EN` is defined.

## Test plan
- Reset, then `start` with 4 words 0x0123456789ABCDEF, 0xFEDCBA9876543210, 0x0, 0xFFFFFFFFFFFFFFFF; `hash_text` = their MSB-first concatenation, `hash_ready` held high → `done` exactly 6 cycles after the last handshake, `match`=1, `fault`=0.
- Same stimulus with bit 0 of `hash_text` flipped → `match`=0, `done` on the same cycle as the matching case (constant time).
- `ref_valid` toggled 1-0-1-0 and `hash_ready` raised 10 cycles after the last word → all 4 words accepted in order; `done` arrives 5 cycles after `hash_ready` rises; `match`=1.
- `start` pulsed during LOAD and again during CMP → ignored; word count and verdict unchanged.
- `rst` asserted during CMP → next cycle all outputs 0 and state IDLE; a fresh transaction then verifies correctly.
- With `HASH_VERIFY_DUAL_EN` defined, force the second accumulator to nonzero on a matching digest → `fault`=1, `match`=0 with `done`.
